// File: rtl/rr_unpack_node.sv
// Merge-tree unpack node: splits one merged packet into independent left and right child streams.
// Each child owns one holding register; counters track delivered payloads per child.
module rr_unpack_node #(
    parameter int unsigned LWIDTH    = 64,
    parameter int unsigned RWIDTH    = 64,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LWIDTH+RWIDTH+1:0] in_data,
    output logic                     l_valid,
    input  logic                     l_ready,
    output logic [LWIDTH-1:0]        l_data,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [RWIDTH-1:0]        r_data,
    output logic [CNT_WIDTH-1:0]     l_count,
    output logic [CNT_WIDTH-1:0]     r_count,
    output logic                     err_empty
);

    logic                 l_present, r_present;
    logic [LWIDTH-1:0]    ldata_in;
    logic [RWIDTH-1:0]    rdata_in;
    logic                 in_fire, l_fire, r_fire;
    logic                 l_pend_q, l_pend_d, r_pend_q, r_pend_d;
    logic [LWIDTH-1:0]    l_data_q;
    logic [RWIDTH-1:0]    r_data_q;
    logic [CNT_WIDTH-1:0] l_count_q, l_count_d, r_count_q, r_count_d;
    logic                 err_q, err_d;

    assign l_present = in_data[LWIDTH+RWIDTH+1];
    assign r_present = in_data[LWIDTH+RWIDTH];
    assign ldata_in  = in_data[LWIDTH+RWIDTH-1:RWIDTH];
    assign rdata_in  = in_data[RWIDTH-1:0];

    always_comb begin
        // A side blocks input only while it holds a payload its consumer will not take this cycle.
        in_ready  = (!l_pend_q || l_ready) && (!r_pend_q || r_ready);
        in_fire   = in_valid && in_ready;
        l_fire    = l_pend_q && l_ready;
        r_fire    = r_pend_q && r_ready;

        l_pend_d  = l_pend_q;
        r_pend_d  = r_pend_q;
        if (l_fire) l_pend_d = 1'b0;
        if (r_fire) r_pend_d = 1'b0;
        // Load-over-clear: a new packet's present bits win over a same-edge drain.
        if (in_fire) begin
            l_pend_d = l_present;
            r_pend_d = r_present;
        end

        l_count_d = l_count_q + {{(CNT_WIDTH-1){1'b0}}, l_fire};
        r_count_d = r_count_q + {{(CNT_WIDTH-1){1'b0}}, r_fire};
        err_d     = err_q | (in_fire && !l_present && !r_present);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l_pend_q  <= 1'b0;
            r_pend_q  <= 1'b0;
            l_count_q <= '0;
            r_count_q <= '0;
            err_q     <= 1'b0;
        end else begin
            l_pend_q  <= l_pend_d;
            r_pend_q  <= r_pend_d;
            l_count_q <= l_count_d;
            r_count_q <= r_count_d;
            err_q     <= err_d;
        end
    end

    // Payload registers carry no reset; the pending flags qualify them.
    always_ff @(posedge clk) begin
        if (in_fire && l_present) l_data_q <= ldata_in;
        if (in_fire && r_present) r_data_q <= rdata_in;
    end

    assign l_valid   = l_pend_q;
    assign r_valid   = r_pend_q;
    assign l_data    = l_data_q;
    assign r_data    = r_data_q;
    assign l_count   = l_count_q;
    assign r_count   = r_count_q;
    assign err_empty = err_q;

endmodule

// File: tb/tb_rr_unpack_node.sv
// Randomized bench for rr_unpack_node with a queue-based reference model of both child streams.
module tb_rr_unpack_node;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic        l_valid, r_valid;
    logic        l_ready = 1'b0, r_ready = 1'b0;
    logic [7:0]  l_data, r_data;
    logic [7:0]  l_count, r_count;
    logic        err_empty;

    int errors = 0;
    int checks = 0;

    // Reference model: what each child still owes its consumer, plus delivered counts.
    logic [7:0] lq[$];
    logic [7:0] rq[$];
    logic [7:0] m_lcnt, m_rcnt;
    logic       m_err;
    bit         acc;

    rr_unpack_node #(
        .LWIDTH(8),
        .RWIDTH(8),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .l_valid(l_valid),
        .l_ready(l_ready),
        .l_data(l_data),
        .r_valid(r_valid),
        .r_ready(r_ready),
        .r_data(r_data),
        .l_count(l_count),
        .r_count(r_count),
        .err_empty(err_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic model_clear();
        lq.delete();
        rq.delete();
        m_lcnt = '0;
        m_rcnt = '0;
        m_err  = 1'b0;
    endtask

    task automatic drive(input bit lp, input bit rp, input logic [7:0] ld, input logic [7:0] rd);
        in_valid = 1'b1;
        in_data  = {lp, rp, ld, rd};
    endtask

    // One clock: score outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit exp_ir, lf, rf;
        @(negedge clk);
        exp_ir = (lq.size() == 0 || l_ready) && (rq.size() == 0 || r_ready);
        checks++;
        if (in_ready !== exp_ir) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_ir);
        end
        checks++;
        if (l_valid !== (lq.size() != 0) || r_valid !== (rq.size() != 0)) begin
            errors++;
            $display("FAIL valids: got l=%b r=%b want l=%b r=%b", l_valid, r_valid,
                     lq.size() != 0, rq.size() != 0);
        end
        if (lq.size() != 0) begin
            checks++;
            if (l_data !== lq[0]) begin
                errors++;
                $display("FAIL l_data: got %h want %h", l_data, lq[0]);
            end
        end
        if (rq.size() != 0) begin
            checks++;
            if (r_data !== rq[0]) begin
                errors++;
                $display("FAIL r_data: got %h want %h", r_data, rq[0]);
            end
        end
        checks++;
        if (l_count !== m_lcnt || r_count !== m_rcnt || err_empty !== m_err) begin
            errors++;
            $display("FAIL counters: got l=%0d r=%0d err=%b want l=%0d r=%0d err=%b",
                     l_count, r_count, err_empty, m_lcnt, m_rcnt, m_err);
        end
        @(posedge clk);
        exp_ir = (lq.size() == 0 || l_ready) && (rq.size() == 0 || r_ready);
        lf = (lq.size() != 0) && l_ready;
        rf = (rq.size() != 0) && r_ready;
        acc = in_valid && exp_ir;
        if (lf) begin void'(lq.pop_front()); m_lcnt++; end
        if (rf) begin void'(rq.pop_front()); m_rcnt++; end
        if (acc) begin
            if (in_data[17]) lq.push_back(in_data[15:8]);
            if (in_data[16]) rq.push_back(in_data[7:0]);
            if (!in_data[17] && !in_data[16]) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        #3;
        checks++;
        if (l_valid !== 1'b0 || r_valid !== 1'b0 || l_count !== 8'd0 || r_count !== 8'd0 ||
            err_empty !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got lv=%b rv=%b lc=%0d rc=%0d err=%b want all 0",
                     l_valid, r_valid, l_count, r_count, err_empty);
        end
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        l_ready = 1'b1;
        r_ready = 1'b1;
        drive(1'b1, 1'b1, 8'hA5, 8'h5A);
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (l_valid !== 1'b1 || r_valid !== 1'b1 || l_data !== 8'hA5 || r_data !== 8'h5A) begin
            errors++;
            $display("FAIL single_out: got lv=%b rv=%b l=%h r=%h want 1 1 a5 5a",
                     l_valid, r_valid, l_data, r_data);
        end
        step();
        step();
        checks++;
        if (l_count !== 8'd1 || r_count !== 8'd1) begin
            errors++;
            $display("FAIL single_count: got l=%0d r=%0d want 1 1", l_count, r_count);
        end
    endtask

    task automatic test_left_only();
        drive(1'b1, 1'b0, 8'h3C, 8'hFF);
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (l_valid !== 1'b1 || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL left_only_valid: got lv=%b rv=%b want 1 0", l_valid, r_valid);
        end
        step();
        step();
        checks++;
        if (l_count !== 8'd2 || r_count !== 8'd1) begin
            errors++;
            $display("FAIL left_only_count: got l=%0d r=%0d want 2 1", l_count, r_count);
        end
    endtask

    task automatic test_left_stall();
        logic [7:0] ld[4];
        logic [7:0] rd[4];
        logic [7:0] l0, r0;
        int         sent;
        l0 = l_count;
        r0 = r_count;
        for (int i = 0; i < 4; i++) begin
            ld[i] = 8'($urandom);
            rd[i] = 8'($urandom);
        end
        l_ready = 1'b0;
        r_ready = 1'b1;
        drive(1'b1, 1'b1, ld[0], rd[0]);
        step();
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL stall_first_accept: got 0 want 1");
        end
        drive(1'b1, 1'b1, ld[1], rd[1]);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
        end
        checks++;
        if (r_count - r0 !== 8'd1 || l_count !== l0) begin
            errors++;
            $display("FAIL stall_counts: got dl=%0d dr=%0d want 0 1", l_count - l0, r_count - r0);
        end
        l_ready = 1'b1;
        sent = 1;
        for (int k = 0; k < 20 && sent < 4; k++) begin
            drive(1'b1, 1'b1, ld[sent], rd[sent]);
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (l_count - l0 !== 8'd4 || r_count - r0 !== 8'd4 || sent != 4) begin
            errors++;
            $display("FAIL stall_drain: got dl=%0d dr=%0d sent=%0d want 4 4 4",
                     l_count - l0, r_count - r0, sent);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] l0, r0, nl, nr;
        bit         lp, rp;
        int         miss;
        l0 = l_count;
        r0 = r_count;
        nl = '0;
        nr = '0;
        miss = 0;
        l_ready = 1'b1;
        r_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            lp = 1'($urandom);
            rp = 1'($urandom);
            if (!lp && !rp) lp = 1'b1;
            nl += 8'(lp);
            nr += 8'(rp);
            drive(lp, rp, 8'($urandom), 8'($urandom));
            step();
            if (!acc) miss++;
        end
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (miss != 0) begin
            errors++;
            $display("FAIL stream_throughput: got %0d stalled cycles want 0", miss);
        end
        checks++;
        if (l_count - l0 !== nl || r_count - r0 !== nr) begin
            errors++;
            $display("FAIL stream_counts: got dl=%0d dr=%0d want %0d %0d",
                     l_count - l0, r_count - r0, nl, nr);
        end
    endtask

    task automatic test_empty();
        logic [7:0] l0, r0;
        int         sent;
        l0 = l_count;
        r0 = r_count;
        l_ready = 1'b1;
        r_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h11, 8'h22);
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (!acc || err_empty !== 1'b1 || l_valid !== 1'b0 || r_valid !== 1'b0 ||
            l_count !== l0 || r_count !== r0) begin
            errors++;
            $display("FAIL empty_packet: got acc=%b err=%b lv=%b rv=%b want 1 1 0 0",
                     acc, err_empty, l_valid, r_valid);
        end
        sent = 0;
        for (int k = 0; k < 60 && sent < 10; k++) begin
            l_ready = 1'($urandom);
            r_ready = 1'($urandom);
            if (!in_valid || acc) drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        l_ready = 1'b1;
        r_ready = 1'b1;
        step();
        step();
        checks++;
        if (err_empty !== 1'b1 || sent != 10) begin
            errors++;
            $display("FAIL empty_sticky: got err=%b sent=%0d want 1 10", err_empty, sent);
        end
    endtask

    task automatic test_backpressure();
        bit lp, rp;
        for (int k = 0; k < 300; k++) begin
            l_ready = ($urandom_range(3) != 0);
            r_ready = ($urandom_range(3) != 0);
            // Hold an offered packet stable until it is taken.
            if (!in_valid || acc) begin
                if ($urandom_range(3) != 0) begin
                    lp = 1'($urandom);
                    rp = 1'($urandom);
                    if (!lp && !rp) rp = 1'b1;
                    drive(lp, rp, 8'($urandom), 8'($urandom));
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
        end
        in_valid = 1'b0;
        l_ready = 1'b1;
        r_ready = 1'b1;
        step();
        step();
        checks++;
        if (lq.size() != 0 || rq.size() != 0 || l_valid !== 1'b0 || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got lv=%b rv=%b want 0 0", l_valid, r_valid);
        end
    endtask

    task automatic test_reset_mid();
        l_ready = 1'b0;
        r_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h77, 8'h00);
        step();
        in_valid = 1'b0;
        checks++;
        if (l_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending: got lv=%b want 1", l_valid);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (l_valid !== 1'b0 || l_count !== 8'd0 || err_empty !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got lv=%b lc=%0d err=%b want 0 0 0",
                     l_valid, l_count, err_empty);
        end
        model_clear();
        #1;
        rstn = 1'b1;
        l_ready = 1'b1;
        step();
        step();
        checks++;
        if (l_count !== 8'd0 || in_ready !== 1'b1 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after: got lc=%0d ir=%b lv=%b want 0 1 0",
                     l_count, in_ready, l_valid);
        end
    endtask

    initial begin
        model_clear();
        acc = 1'b0;
        test_reset();
        test_single();
        test_left_only();
        test_left_stall();
        test_random_stream();
        test_empty();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
